// File: rtl/latch_bank_pkg.sv
// ---------------------------------------------------------------------------
// latch_bank_pkg
// Shared constants for the latch_bank slice.
//   MODE_TRANSPARENT : latch follows d while the strobe is high and holds on
//                      the falling strobe (classic transparent-latch timing,
//                      retimed to the clock)
//   MODE_EDGE        : latch captures d once, on the rising strobe cycle
// ---------------------------------------------------------------------------
package latch_bank_pkg;

    localparam logic MODE_TRANSPARENT = 1'b0;
    localparam logic MODE_EDGE        = 1'b1;

endpackage

// File: rtl/latch_channel.sv
// ---------------------------------------------------------------------------
// latch_channel
// One WIDTH-bit latch channel with its own strobe edge detector, sticky
// valid/overrun status and a wrapping capture-event counter.
// Ports:
//   clk      in   system clock, all state updates on rising edge
//   reset    in   asynchronous active-high reset, clears all state
//   d        in   WIDTH-bit data for this channel
//   g        in   strobe, synchronous to clk
//   mode     in   MODE_TRANSPARENT or MODE_EDGE, sampled every cycle
//   ack      in   consumer read acknowledge, clears valid
//   clr_ovr  in   clears the overrun flag
//   rq       out  latched data
//   valid    out  sticky "new data captured" flag
//   overrun  out  sticky "captured again before the previous one was acked"
//   cnt      out  CNT_W-bit capture-event counter, wraps
// ---------------------------------------------------------------------------
module latch_channel
    import latch_bank_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             g,
    input  logic             mode,
    input  logic             ack,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] rq,
    output logic             valid,
    output logic             overrun,
    output logic [CNT_W-1:0] cnt
);

    logic g_q;
    logic rise;
    logic fall;
    logic load;
    logic capture;

    assign rise = g & ~g_q;
    assign fall = ~g & g_q;

    // Transparent mode reloads the register every strobed cycle and
    // declares the capture when the strobe drops, so the held value is
    // the data of the last strobed cycle. Edge mode loads and captures
    // together on the single rise cycle.
    always_comb begin
        load    = 1'b0;
        capture = 1'b0;
        if (mode == MODE_EDGE) begin
            load    = rise;
            capture = rise;
        end else begin
            load    = g;
            capture = fall;
        end
    end

    // Channel state. Because g_q clears in reset, a strobe already high
    // when reset releases is seen as a rise on the first clock.
    // A capture always wins over ack for valid, and setting overrun
    // wins over clr_ovr in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q     <= 1'b0;
            rq      <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
            cnt     <= '0;
        end else begin
            g_q <= g;

            if (load) begin
                rq <= d;
            end

            if (capture) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (capture) begin
                valid <= 1'b1;
            end else if (ack) begin
                valid <= 1'b0;
            end

            if (capture && valid && !ack) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/latch_bank.sv
// ---------------------------------------------------------------------------
// latch_bank
// CHANNELS independent WIDTH-bit latch channels sharing one active-low
// tri-state output enable.
// Ports:
//   clk      in     system clock
//   reset    in     asynchronous active-high reset
//   d        in     data in, channel c = d[c*WIDTH +: WIDTH]
//   g        in     per-channel strobe
//   mode     in     0 = transparent, 1 = edge capture
//   oe_n     in     active-low output enable for all channels
//   q        inout  latched data, released to 'z when oe_n = 1
//   ack      in     per-channel read acknowledge
//   clr_ovr  in     clears all overrun flags
//   valid    out    per-channel sticky valid
//   overrun  out    per-channel sticky overrun
//   cnt      out    per-channel capture counters, channel c = cnt[c*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module latch_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*CHANNELS-1:0] d,
    input  logic [CHANNELS-1:0]       g,
    input  logic                      mode,
    input  logic                      oe_n,
    inout  wire  [WIDTH*CHANNELS-1:0] q,
    input  logic [CHANNELS-1:0]       ack,
    input  logic                      clr_ovr,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       overrun,
    output logic [CNT_W*CHANNELS-1:0] cnt
);

    logic [WIDTH*CHANNELS-1:0] rq_bus;

    // One channel per strobe; channels share nothing but mode and clr_ovr.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        latch_channel #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .d       (d[c*WIDTH +: WIDTH]),
            .g       (g[c]),
            .mode    (mode),
            .ack     (ack[c]),
            .clr_ovr (clr_ovr),
            .rq      (rq_bus[c*WIDTH +: WIDTH]),
            .valid   (valid[c]),
            .overrun (overrun[c]),
            .cnt     (cnt[c*CNT_W +: CNT_W])
        );
    end

    // The output driver is purely combinational so enable/disable take
    // effect with no clock latency, including while reset is held.
    assign q = oe_n ? {(WIDTH*CHANNELS){1'bz}} : rq_bus;

endmodule

// File: tb/tb_latch_bank.sv
// ---------------------------------------------------------------------------
// tb_latch_bank
// Directed bench for latch_bank with a scoreboard queue of expected values.
// The q bus carries pull-ups, so a released bus reads back as all ones.
// ---------------------------------------------------------------------------
module tb_latch_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;
    localparam int CNT_W    = 4;
    localparam int NQ       = WIDTH * CHANNELS;

    logic                      clk;
    logic                      reset;
    logic [NQ-1:0]             d;
    logic [CHANNELS-1:0]       g;
    logic                      mode;
    logic                      oe_n;
    wire  [NQ-1:0]             q;
    logic [CHANNELS-1:0]       ack;
    logic                      clr_ovr;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       overrun;
    logic [CNT_W*CHANNELS-1:0] cnt;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       tag;
        logic [23:0] value;
    } exp_t;

    exp_t sb[$];

    latch_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .d       (d),
        .g       (g),
        .mode    (mode),
        .oe_n    (oe_n),
        .q       (q),
        .ack     (ack),
        .clr_ovr (clr_ovr),
        .valid   (valid),
        .overrun (overrun),
        .cnt     (cnt)
    );

    // Weak pull-ups make the released bus observable as all ones.
    for (genvar i = 0; i < NQ; i++) begin : g_pu
        pullup (q[i]);
    end

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the strobe/control inputs and let one clock edge pass.
    task automatic apply_stimulus(input logic [2:0] g_v, input logic m,
                                  input logic [2:0] ack_v, input logic clr_v);
        g       = g_v;
        mode    = m;
        ack     = ack_v;
        clr_ovr = clr_v;
        tick();
    endtask

    task automatic set_d(input int ch, input logic [7:0] v);
        d[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic push_exp(input string tag, input logic [23:0] v);
        exp_t e;
        e.tag   = tag;
        e.value = v;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare the observed value against it.
    task automatic check_output(input logic [23:0] obs);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value)
            else begin
                mismatched++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        d       = '0;
        g       = '0;
        mode    = 1'b0;
        oe_n    = 1'b0;
        ack     = '0;
        clr_ovr = 1'b0;

        // ---- 1. reset state and output enable
        $display("[TB] reset state");
        push_exp("rst_q",       24'h000000);
        push_exp("rst_valid",   24'h000000);
        push_exp("rst_overrun", 24'h000000);
        push_exp("rst_cnt",     24'h000000);
        tick();
        check_output(q);
        check_output({21'b0, valid});
        check_output({21'b0, overrun});
        check_output({12'b0, cnt});
        push_exp("oe_off_q", 24'hFFFFFF);
        oe_n = 1'b1;
        #1;
        check_output(q);
        oe_n  = 1'b0;
        reset = 1'b0;

        // ---- 2. transparent mode on channel 0
        $display("[TB] transparent mode ch0");
        set_d(0, 8'hA5);
        apply_stimulus(3'b001, 1'b0, 3'b000, 1'b0);
        apply_stimulus(3'b001, 1'b0, 3'b000, 1'b0);
        push_exp("tr_follow_q0",  24'h0000A5);
        push_exp("tr_open_valid", 24'h000000);
        check_output({16'b0, q[7:0]});
        check_output({21'b0, valid});
        set_d(0, 8'h3C);
        apply_stimulus(3'b001, 1'b0, 3'b000, 1'b0);
        push_exp("tr_hold_q0",  24'h00003C);
        push_exp("tr_valid",    24'h000001);
        push_exp("tr_cnt",      24'h000001);
        apply_stimulus(3'b000, 1'b0, 3'b000, 1'b0);
        check_output({16'b0, q[7:0]});
        check_output({21'b0, valid});
        check_output({12'b0, cnt});
        push_exp("tr_closed_q0", 24'h00003C);
        set_d(0, 8'hFF);
        apply_stimulus(3'b000, 1'b0, 3'b000, 1'b0);
        apply_stimulus(3'b000, 1'b0, 3'b000, 1'b0);
        check_output({16'b0, q[7:0]});

        // ---- 3. edge mode on channel 1
        $display("[TB] edge mode ch1");
        set_d(1, 8'h55);
        push_exp("edge_q1",    24'h000055);
        push_exp("edge_cnt",   24'h000011);
        push_exp("edge_valid", 24'h000003);
        apply_stimulus(3'b010, 1'b1, 3'b000, 1'b0);
        set_d(1, 8'hAA);
        apply_stimulus(3'b010, 1'b1, 3'b000, 1'b0);
        apply_stimulus(3'b010, 1'b1, 3'b000, 1'b0);
        check_output({16'b0, q[15:8]});
        check_output({12'b0, cnt});
        check_output({21'b0, valid});
        push_exp("edge_fall_cnt", 24'h000011);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        check_output({12'b0, cnt});

        // ---- 4. overrun / ack / clr_ovr on channel 2
        $display("[TB] status flags ch2");
        set_d(2, 8'h11);
        apply_stimulus(3'b100, 1'b1, 3'b000, 1'b0);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        set_d(2, 8'h22);
        push_exp("ovr_set",   24'h000004);
        push_exp("ovr_valid", 24'h000007);
        push_exp("ovr_cnt",   24'h000211);
        apply_stimulus(3'b100, 1'b1, 3'b000, 1'b0);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        check_output({21'b0, overrun});
        check_output({21'b0, valid});
        check_output({12'b0, cnt});
        set_d(2, 8'h33);
        push_exp("cap_ack_valid", 24'h000007);
        push_exp("cap_ack_cnt",   24'h000311);
        apply_stimulus(3'b100, 1'b1, 3'b100, 1'b0);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        check_output({21'b0, valid});
        check_output({12'b0, cnt});
        push_exp("ack_clears_valid", 24'h000003);
        apply_stimulus(3'b000, 1'b1, 3'b100, 1'b0);
        check_output({21'b0, valid});
        set_d(2, 8'h44);
        apply_stimulus(3'b100, 1'b1, 3'b000, 1'b0);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        set_d(2, 8'h55);
        push_exp("ovr_set_wins", 24'h000004);
        apply_stimulus(3'b100, 1'b1, 3'b000, 1'b1);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        check_output({21'b0, overrun});
        push_exp("clr_ovr",   24'h000000);
        push_exp("bank_q",    24'h55553C);
        push_exp("clr_cnt",   24'h000511);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b1);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        check_output({21'b0, overrun});
        check_output(q);
        check_output({12'b0, cnt});

        // ---- 5. counter wrap on channel 0 in edge mode
        $display("[TB] counter wrap ch0");
        push_exp("cnt_at_15", 24'h00051F);
        for (int i = 0; i < 14; i++) begin
            set_d(0, 8'(8'h60 + i));
            apply_stimulus(3'b001, 1'b1, 3'b000, 1'b0);
            apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        end
        check_output({12'b0, cnt});
        push_exp("cnt_wrap_0", 24'h000510);
        apply_stimulus(3'b001, 1'b1, 3'b000, 1'b0);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        check_output({12'b0, cnt});
        set_d(0, 8'h7E);
        push_exp("cnt_after_16", 24'h000511);
        push_exp("wrap_q0",      24'h00007E);
        push_exp("wrap_overrun", 24'h000001);
        push_exp("wrap_valid",   24'h000007);
        apply_stimulus(3'b001, 1'b1, 3'b000, 1'b0);
        apply_stimulus(3'b000, 1'b1, 3'b000, 1'b0);
        check_output({12'b0, cnt});
        check_output({16'b0, q[7:0]});
        check_output({21'b0, overrun});
        check_output({21'b0, valid});

        // ---- 6. reset mid-strobe, release with strobes high in edge mode
        $display("[TB] reset mid-strobe");
        d = 24'h9A7856;
        apply_stimulus(3'b111, 1'b1, 3'b000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        push_exp("midrst_q",       24'h000000);
        push_exp("midrst_valid",   24'h000000);
        push_exp("midrst_overrun", 24'h000000);
        push_exp("midrst_cnt",     24'h000000);
        check_output(q);
        check_output({21'b0, valid});
        check_output({21'b0, overrun});
        check_output({12'b0, cnt});
        tick();
        reset = 1'b0;
        push_exp("release_valid_pre", 24'h000000);
        check_output({21'b0, valid});
        push_exp("release_valid", 24'h000007);
        push_exp("release_cnt",   24'h000111);
        push_exp("release_q",     24'h9A7856);
        tick();
        check_output({21'b0, valid});
        check_output({12'b0, cnt});
        check_output(q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
